// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset/stall sequencer.
//   state_e        : sequencer FSM states
//   STALL_*        : stall_mode encodings
//   LFSR_TAP_MASK  : Fibonacci taps 16,14,13,11 for a right-shifting register
//   lfsr_next()    : one LFSR step
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        ASSERT    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam logic [1:0] STALL_OFF      = 2'b00;
    localparam logic [1:0] STALL_TOGGLE   = 2'b01;
    localparam logic [1:0] STALL_PERIODIC = 2'b10;
    localparam logic [1:0] STALL_RANDOM   = 2'b11;

    // Taps 16,14,13,11 map to bits 0,2,3,5 when shifting right.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronizer chain followed by a stable-count debouncer.
//   clk   : clock
//   rst   : synchronous active-high reset
//   d_in  : raw asynchronous input
//   d_out : synchronized, debounced level
// d_out follows a new input level SYNC_STAGES+DEBOUNCE_CYCLES cycles after it
// first appears; shorter excursions are dropped.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          dcnt_q, dcnt_d;
    logic                   db_q, db_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign d_out  = db_q;

    // Count consecutive cycles that disagree with the current level; any
    // agreeing cycle restarts the count.
    always_comb begin
        dcnt_d = '0;
        db_d   = db_q;
        if (synced != db_q) begin
            if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                dcnt_d = dcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dcnt_q <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            dcnt_q <= dcnt_d;
            db_q   <= db_d;
        end
    end

endmodule

// File: rtl/reset_stall_sequencer.sv
// Reset and stall sequencer for the CPU clock domain.
//   clk        : CPU clock
//   rst        : synchronous active-high global reset
//   btn_in     : raw push-button, active-high
//   lock_in    : asynchronous lock flags, all must be high
//   stall_mode : 00 off, 01 toggle, 10 periodic, 11 pseudo-random
//   cpu_rst    : registered core reset
//   stall      : registered core stall
//   ready      : registered, high while the FSM is in RUN
module reset_stall_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_LOCKS       = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RST_CYCLES      = 15,
    parameter int unsigned STALL_PERIOD    = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_in,
    input  logic [NUM_LOCKS-1:0] lock_in,
    input  logic [1:0]           stall_mode,
    output logic                 cpu_rst,
    output logic                 stall,
    output logic                 ready
);

    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
    localparam int unsigned SCW = $clog2(STALL_PERIOD);

    state_e                 state_q, state_d;
    logic [RCW-1:0]         rcnt_q, rcnt_d;
    logic [NUM_LOCKS-1:0]   lock_s1_q, lock_s2_q;
    logic                   locks_ok;
    logic                   btn_db;

    logic                   cpu_rst_q, cpu_rst_d;
    logic                   ready_q, ready_d;
    logic                   stall_q, stall_d;
    logic [1:0]             mode_q;
    logic                   tog_q, tog_d;
    logic [SCW-1:0]         scnt_q, scnt_d;
    logic [15:0]            lfsr_q, lfsr_d;

    logic                   run_next;
    logic                   restart;

    assign cpu_rst  = cpu_rst_q;
    assign ready    = ready_q;
    assign stall    = stall_q;
    assign locks_ok = &lock_s2_q;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk   (clk),
        .rst   (rst),
        .d_in  (btn_in),
        .d_out (btn_db)
    );

    // Lock synchronizers, FSM state and reset counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_s1_q <= '0;
            lock_s2_q <= '0;
            state_q   <= WAIT_LOCK;
            rcnt_q    <= '0;
        end else begin
            lock_s1_q <= lock_in;
            lock_s2_q <= lock_s1_q;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Next state; lock loss always wins over the button.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locks_ok) begin
                    state_d = ASSERT;
                    rcnt_d  = RCW'(RST_CYCLES - 1);
                end
            end
            ASSERT: begin
                if (!locks_ok) begin
                    state_d = WAIT_LOCK;
                    rcnt_d  = '0;
                end else if (btn_db) begin
                    rcnt_d = RCW'(RST_CYCLES - 1);
                end else if (rcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
            end
            RUN: begin
                if (!locks_ok) begin
                    state_d = WAIT_LOCK;
                    rcnt_d  = '0;
                end else if (btn_db) begin
                    state_d = ASSERT;
                    rcnt_d  = RCW'(RST_CYCLES - 1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                rcnt_d  = '0;
            end
        endcase
    end

    // Outputs and stall generator, all derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        run_next  = (state_d == RUN);
        restart   = run_next && ((state_q != RUN) || (stall_mode != mode_q));
        cpu_rst_d = !run_next;
        ready_d   = run_next;
        stall_d   = 1'b0;
        tog_d     = 1'b0;
        scnt_d    = '0;
        lfsr_d    = lfsr_q;
        if (run_next) begin
            lfsr_d = lfsr_next(lfsr_q);
            tog_d  = restart ? 1'b1 : ~tog_q;
            if (!restart) begin
                scnt_d = (scnt_q == SCW'(STALL_PERIOD - 1)) ? '0 : scnt_q + SCW'(1);
            end
            unique case (stall_mode)
                STALL_OFF:      stall_d = 1'b0;
                STALL_TOGGLE:   stall_d = tog_d;
                STALL_PERIODIC: stall_d = (scnt_d == SCW'(STALL_PERIOD - 1));
                STALL_RANDOM:   stall_d = lfsr_q[0];
                default:        stall_d = 1'b0;
            endcase
        end
    end

    // Output and stall-generator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            stall_q   <= 1'b0;
            mode_q    <= STALL_OFF;
            tog_q     <= 1'b0;
            scnt_q    <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            cpu_rst_q <= cpu_rst_d;
            ready_q   <= ready_d;
            stall_q   <= stall_d;
            mode_q    <= stall_mode;
            tog_q     <= tog_d;
            scnt_q    <= scnt_d;
            lfsr_q    <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_reset_stall_sequencer.sv
// Directed bench for reset_stall_sequencer with default parameters.
// Edge k is the k-th rising edge after inputs are changed; outputs are
// sampled 1 time unit after each edge.
module tb_reset_stall_sequencer;
    import rst_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic [1:0] lock_in = 2'b00;
    logic [1:0] stall_mode = 2'b00;
    logic       cpu_rst, stall, ready;

    int total = 0;
    int bad   = 0;

    reset_stall_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .lock_in    (lock_in),
        .stall_mode (stall_mode),
        .cpu_rst    (cpu_rst),
        .stall      (stall),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] m);
        logic fb;
        fb = m[0] ^ m[2] ^ m[3] ^ m[5];
        return {fb, m[15:1]};
    endfunction

    // T1: reset values, then release with locks good -> RUN at edge 18.
    task automatic test_reset();
        logic [2:0] exp_v;
        rst = 1'b1; lock_in = 2'b11; btn_in = 1'b0; stall_mode = 2'b00;
        repeat (3) step();
        total++;
        if ({cpu_rst, ready, stall} !== 3'b100) begin
            bad++;
            $display("FAIL reset_vals got={cpu_rst,ready,stall}=%b exp=%b", {cpu_rst, ready, stall}, 3'b100);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_v = (k < 18) ? 3'b100 : 3'b010;
            total++;
            if ({cpu_rst, ready, stall} !== exp_v) begin
                bad++;
                $display("FAIL t1_startup k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, exp_v);
            end
        end
    endtask

    // T2: short glitch rejected; long press resets from edge 19 until 15
    // cycles after the debounced release.
    task automatic test_button();
        logic [2:0] exp_v;
        btn_in = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            if (k == 11) btn_in = 1'b0;
            step();
            total++;
            if ({cpu_rst, ready, stall} !== 3'b010) begin
                bad++;
                $display("FAIL t2_glitch k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, 3'b010);
            end
        end
        btn_in = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            if (k == 41) btn_in = 1'b0;
            step();
            exp_v = (k >= 19 && k < 73) ? 3'b100 : 3'b010;
            total++;
            if ({cpu_rst, ready, stall} !== exp_v) begin
                bad++;
                $display("FAIL t2_press k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, exp_v);
            end
        end
    endtask

    // T3: one-cycle lock drop in RUN, with toggle stall to see RUN re-entry.
    task automatic test_lock_drop();
        logic [2:0] exp_v;
        logic       exp_s;
        stall_mode = STALL_TOGGLE;
        lock_in    = 2'b01;
        for (int k = 1; k <= 24; k++) begin
            if (k == 2) lock_in = 2'b11;
            step();
            if (k == 1)       exp_s = 1'b1;
            else if (k < 19)  exp_s = 1'b0;
            else              exp_s = ((k - 19) % 2 == 0);
            exp_v = (k >= 3 && k <= 18) ? {2'b10, exp_s} : {2'b01, exp_s};
            total++;
            if ({cpu_rst, ready, stall} !== exp_v) begin
                bad++;
                $display("FAIL t3_lock_drop k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, exp_v);
            end
        end
    endtask

    // T4: locks lost during a held press; release while locks are down, so
    // RUN must wait for the locks rather than the button.
    task automatic test_lock_over_button();
        logic [2:0] exp_v;
        stall_mode = STALL_OFF;
        btn_in     = 1'b1;
        for (int k = 1; k <= 82; k++) begin
            if (k == 26) lock_in = 2'b00;
            if (k == 31) btn_in  = 1'b0;
            if (k == 61) lock_in = 2'b11;
            step();
            exp_v = (k >= 19 && k < 78) ? 3'b100 : 3'b010;
            total++;
            if ({cpu_rst, ready, stall} !== exp_v) begin
                bad++;
                $display("FAIL t4_lock_prio k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, exp_v);
            end
        end
    endtask

    // T5: random from seed, then toggle, periodic, off, random (LFSR kept running).
    task automatic test_stall_modes();
        logic [15:0] m;
        logic [2:0]  exp_v;
        logic        exp_s;
        rst = 1'b1; lock_in = 2'b11; btn_in = 1'b0; stall_mode = STALL_RANDOM;
        repeat (2) step();
        rst = 1'b0;
        m   = 16'hACE1;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k >= 18) begin
                exp_s = m[0];
                m     = ref_lfsr(m);
            end else begin
                exp_s = 1'b0;
            end
            exp_v = (k < 18) ? 3'b100 : {2'b01, exp_s};
            total++;
            if ({cpu_rst, ready, stall} !== exp_v) begin
                bad++;
                $display("FAIL t5_random k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, exp_v);
            end
        end
        stall_mode = STALL_TOGGLE;
        for (int j = 0; j < 8; j++) begin
            step();
            m = ref_lfsr(m);
            exp_s = (j % 2 == 0);
            total++;
            if (stall !== exp_s) begin
                bad++;
                $display("FAIL t5_toggle j=%0d got=%b exp=%b", j, stall, exp_s);
            end
        end
        stall_mode = STALL_PERIODIC;
        for (int j = 0; j < 12; j++) begin
            step();
            m = ref_lfsr(m);
            exp_s = (j % 4 == 3);
            total++;
            if (stall !== exp_s) begin
                bad++;
                $display("FAIL t5_periodic j=%0d got=%b exp=%b", j, stall, exp_s);
            end
        end
        stall_mode = STALL_OFF;
        for (int j = 0; j < 4; j++) begin
            step();
            m = ref_lfsr(m);
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL t5_off j=%0d got=%b exp=0", j, stall);
            end
        end
        stall_mode = STALL_RANDOM;
        for (int j = 0; j < 8; j++) begin
            step();
            exp_s = m[0];
            m     = ref_lfsr(m);
            total++;
            if (stall !== exp_s) begin
                bad++;
                $display("FAIL t5_random_cont j=%0d got=%b exp=%b", j, stall, exp_s);
            end
        end
    endtask

    // T6: reset while in ASSERT with rcnt=7; everything restarts from scratch.
    task automatic test_reset_mid_assert();
        logic [15:0] m;
        logic [2:0]  exp_v;
        logic        exp_s;
        lock_in = 2'b10;
        for (int k = 1; k <= 11; k++) begin
            if (k == 2) lock_in = 2'b11;
            step();
            exp_v = (k >= 3) ? 3'b100 : 3'b01x;
            total++;
            if (cpu_rst !== exp_v[2]) begin
                bad++;
                $display("FAIL t6_enter_assert k=%0d got=%b exp=%b", k, cpu_rst, exp_v[2]);
            end
        end
        total++;
        if (dut.rcnt_q !== 4'd7) begin
            bad++;
            $display("FAIL t6_rcnt_before got=%0d exp=7", dut.rcnt_q);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({cpu_rst, ready, stall} !== 3'b100) begin
            bad++;
            $display("FAIL t6_reset_outs got=%b exp=100", {cpu_rst, ready, stall});
        end
        total++;
        if (dut.state_q !== WAIT_LOCK || dut.rcnt_q !== 4'd0 || dut.lfsr_q !== 16'hACE1) begin
            bad++;
            $display("FAIL t6_reset_state got state=%0d rcnt=%0d lfsr=%h exp state=0 rcnt=0 lfsr=ace1",
                     dut.state_q, dut.rcnt_q, dut.lfsr_q);
        end
        m = 16'hACE1;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k >= 18) begin
                exp_s = m[0];
                m     = ref_lfsr(m);
            end else begin
                exp_s = 1'b0;
            end
            exp_v = (k < 18) ? 3'b100 : {2'b01, exp_s};
            total++;
            if ({cpu_rst, ready, stall} !== exp_v) begin
                bad++;
                $display("FAIL t6_restart k=%0d got=%b exp=%b", k, {cpu_rst, ready, stall}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_button();
        test_lock_drop();
        test_lock_over_button();
        test_stall_modes();
        test_reset_mid_assert();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
